// File: rtl/cache_refill_ctrl_pkg.sv
// Shared cache refill definitions: FSM state
// encoding and line-address alignment mask.
package cache_refill_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  function automatic logic [63:0] line_mask(
    input int offset_bits
  );
    logic [63:0] m;
    m = '1;
    m = m << offset_bits;
    return m;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Memory-side request/ack bus of the refill
// controller; master is the controller.
interface cache_refill_ctrl_if #(
  parameter int AW = 32,
  parameter int LW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [LW-1:0] wdata;
  logic          ack;
  logic [LW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/cache_refill_ctrl_wb_buffer.sv
// One-entry write-back buffer for evicted lines
// with a sticky overflow flag.
module cache_refill_ctrl_wb_buffer #(
  parameter int AW = 32,
  parameter int LW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [AW-1:0] i_addr,
  input  logic [LW-1:0] i_data,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [LW-1:0] o_data,
  output logic          o_overflow
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          free;

  // A clear on this edge frees the slot for a
  // coincident load.
  assign free = !valid_q || i_clear;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (i_clear) valid_d = 1'b0;
    if (i_load) begin
      if (free) begin
        valid_d = 1'b1;
        addr_d  = i_addr;
        data_d  = i_data;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_overflow = ovf_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: drains a one-entry
// write-back buffer, then services line misses.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int LINE_SIZE_BITS = 32,
  parameter int OFFSET_BITS    = 6,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_miss,
  input  logic [ADDRESS_WIDTH-1:0]  i_miss_addr,
  input  logic                      i_evict,
  input  logic [ADDRESS_WIDTH-1:0]  i_evict_addr,
  input  logic [LINE_SIZE_BITS-1:0] i_evict_data,
  output logic [LINE_SIZE_BITS-1:0] o_memory_line,
  output logic                      o_memory_response,
  cache_refill_ctrl_if.master       mem,
  output logic                      o_busy,
  output logic                      o_timeout,
  output logic                      o_overflow
);

  localparam int CW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [63:0] MASK_FULL =
    line_mask(OFFSET_BITS);
  localparam logic [ADDRESS_WIDTH-1:0] MASK =
    MASK_FULL[ADDRESS_WIDTH-1:0];
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  logic [1:0]                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [LINE_SIZE_BITS-1:0] line_q, line_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      timeout_q, timeout_d;

  logic                      wb_valid;
  logic [ADDRESS_WIDTH-1:0]  wb_addr;
  logic [LINE_SIZE_BITS-1:0] wb_data;
  logic                      wb_ovf;
  logic                      wb_clear;

  logic is_idle, is_wb, is_rd, is_resp;
  logic [CW-1:0] cnt_inc;

  assign is_idle = (state_q == S_IDLE);
  assign is_wb   = (state_q == S_WB);
  assign is_rd   = (state_q == S_RD);
  assign is_resp = (state_q == S_RESP);

  assign wb_clear = is_wb && mem.ack;
  assign cnt_inc  =
    (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  cache_refill_ctrl_wb_buffer #(
    .AW (ADDRESS_WIDTH),
    .LW (LINE_SIZE_BITS)
  ) wb_buffer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (i_evict),
    .i_clear    (wb_clear),
    .i_addr     (i_evict_addr),
    .i_data     (i_evict_data),
    .o_valid    (wb_valid),
    .o_addr     (wb_addr),
    .o_data     (wb_data),
    .o_overflow (wb_ovf)
  );

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (1'b1)
      is_idle: begin
        if (wb_valid) begin
          state_d = S_WB;
          cnt_d   = '0;
        end else if (i_miss) begin
          state_d   = S_RD;
          rd_addr_d = i_miss_addr & MASK;
          cnt_d     = '0;
        end
      end
      is_wb: begin
        if (mem.ack) state_d = S_IDLE;
        else         cnt_d   = cnt_inc;
      end
      is_rd: begin
        if (mem.ack) begin
          line_d  = mem.rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      is_resp: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flag only; the wait itself continues.
    if ((is_wb || is_rd) && !mem.ack &&
        cnt_d >= TO_LIM)
      timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      line_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem.req   = is_wb || is_rd;
  assign mem.we    = is_wb;
  assign mem.addr  =
    is_wb ? (wb_addr & MASK) :
    is_rd ? rd_addr_q : '0;
  assign mem.wdata = is_wb ? wb_data : '0;

  assign o_memory_line     = line_q;
  assign o_memory_response = is_resp;
  assign o_busy            = !is_idle || wb_valid;
  assign o_timeout         = timeout_q;
  assign o_overflow        = wb_ovf;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with
// hand-computed expectations.
module tb_cache_refill_ctrl;

  logic        clk;
  logic        rst;
  logic        i_miss;
  logic [31:0] i_miss_addr;
  logic        i_evict;
  logic [31:0] i_evict_addr;
  logic [31:0] i_evict_data;
  logic [31:0] o_memory_line;
  logic        o_memory_response;
  logic        o_busy;
  logic        o_timeout;
  logic        o_overflow;

  int n_cmp = 0;
  int n_err = 0;

  cache_refill_ctrl_if #(.AW(32), .LW(32)) mem ();

  cache_refill_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_miss            (i_miss),
    .i_miss_addr       (i_miss_addr),
    .i_evict           (i_evict),
    .i_evict_addr      (i_evict_addr),
    .i_evict_data      (i_evict_data),
    .o_memory_line     (o_memory_line),
    .o_memory_response (o_memory_response),
    .mem               (mem.master),
    .o_busy            (o_busy),
    .o_timeout         (o_timeout),
    .o_overflow        (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_req"},  32'(mem.req), 32'd0);
    chk({tag, "_addr"}, mem.addr, 32'd0);
    chk({tag, "_resp"}, 32'(o_memory_response),
        32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    i_miss       = 1'b0;
    i_miss_addr  = '0;
    i_evict      = 1'b0;
    i_evict_addr = '0;
    i_evict_data = '0;
    mem.ack      = 1'b0;
    mem.rdata    = '0;
    #1;
    chk_idle_zero("rst");
    chk("rst_line", o_memory_line, 32'd0);
    chk("rst_to", 32'(o_timeout), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // clean miss, alignment, miss drop in RD
    i_miss      = 1'b1;
    i_miss_addr = 32'h0000_1234;
    tick();
    chk("m1_req", 32'(mem.req), 32'd1);
    chk("m1_we", 32'(mem.we), 32'd0);
    chk("m1_addr", mem.addr, 32'h0000_1200);
    chk("m1_busy", 32'(o_busy), 32'd1);
    i_miss      = 1'b0;
    i_miss_addr = 32'hFFFF_FFFF;
    tick();
    chk("m1_addr_hold", mem.addr, 32'h0000_1200);
    chk("m1_req_hold", 32'(mem.req), 32'd1);
    mem.ack   = 1'b1;
    mem.rdata = 32'hDEAD_BEEF;
    tick();
    mem.ack = 1'b0;
    chk("m1_resp", 32'(o_memory_response), 32'd1);
    chk("m1_line", o_memory_line, 32'hDEAD_BEEF);
    chk("m1_req_off", 32'(mem.req), 32'd0);
    tick();
    chk("m1_resp_off", 32'(o_memory_response),
        32'd0);
    chk("m1_line_hold", o_memory_line,
        32'hDEAD_BEEF);
    chk("m1_busy_off", 32'(o_busy), 32'd0);

    // evict then miss: write-back first
    i_evict      = 1'b1;
    i_evict_addr = 32'h40;
    i_evict_data = 32'h11;
    tick();
    i_evict     = 1'b0;
    i_miss      = 1'b1;
    i_miss_addr = 32'h80;
    chk("e1_busy", 32'(o_busy), 32'd1);
    chk("e1_req", 32'(mem.req), 32'd0);
    tick();
    chk("e1_wb_req", 32'(mem.req), 32'd1);
    chk("e1_wb_we", 32'(mem.we), 32'd1);
    chk("e1_wb_addr", mem.addr, 32'h40);
    chk("e1_wb_data", mem.wdata, 32'h11);
    mem.ack = 1'b1;
    tick();
    mem.ack = 1'b0;
    chk("e1_idle_req", 32'(mem.req), 32'd0);
    tick();
    chk("e1_rd_req", 32'(mem.req), 32'd1);
    chk("e1_rd_we", 32'(mem.we), 32'd0);
    chk("e1_rd_addr", mem.addr, 32'h80);
    mem.ack   = 1'b1;
    mem.rdata = 32'h0000_CAFE;
    tick();
    mem.ack = 1'b0;
    i_miss  = 1'b0;
    chk("e1_resp", 32'(o_memory_response), 32'd1);
    chk("e1_line", o_memory_line, 32'h0000_CAFE);
    tick();

    // overflow: second evict while full
    i_evict      = 1'b1;
    i_evict_addr = 32'h100;
    i_evict_data = 32'hAA;
    tick();
    chk("o1_ovf_pre", 32'(o_overflow), 32'd0);
    i_evict_addr = 32'h200;
    i_evict_data = 32'hBB;
    tick();
    i_evict = 1'b0;
    chk("o1_ovf", 32'(o_overflow), 32'd1);
    chk("o1_we", 32'(mem.we), 32'd1);
    chk("o1_addr", mem.addr, 32'h100);
    chk("o1_data", mem.wdata, 32'hAA);
    mem.ack = 1'b1;
    tick();
    mem.ack = 1'b0;
    tick();
    chk("o1_drain", 32'(o_busy), 32'd0);
    chk("o1_ovf_sticky", 32'(o_overflow), 32'd1);

    // timeout: ack withheld 300 cycles
    i_miss      = 1'b1;
    i_miss_addr = 32'h0000_3010;
    tick();
    chk("t1_req", 32'(mem.req), 32'd1);
    repeat (254) tick();
    chk("t1_to_254", 32'(o_timeout), 32'd0);
    tick();
    chk("t1_to_255", 32'(o_timeout), 32'd1);
    repeat (45) tick();
    chk("t1_still_req", 32'(mem.req), 32'd1);
    chk("t1_addr", mem.addr, 32'h0000_3000);
    mem.ack   = 1'b1;
    mem.rdata = 32'h0000_0055;
    tick();
    mem.ack = 1'b0;
    i_miss  = 1'b0;
    chk("t1_resp", 32'(o_memory_response), 32'd1);
    chk("t1_line", o_memory_line, 32'h55);
    tick();
    chk("t1_to_sticky", 32'(o_timeout), 32'd1);

    // reset during RD abandons the read
    i_miss      = 1'b1;
    i_miss_addr = 32'h0000_4000;
    tick();
    chk("r1_req", 32'(mem.req), 32'd1);
    rst = 1'b1;
    #1;
    chk_idle_zero("r1");
    chk("r1_line", o_memory_line, 32'd0);
    chk("r1_to", 32'(o_timeout), 32'd0);
    chk("r1_ovf", 32'(o_overflow), 32'd0);
    i_miss = 1'b0;
    tick();
    rst       = 1'b0;
    mem.ack   = 1'b1;
    mem.rdata = 32'h0000_0099;
    tick();
    mem.ack = 1'b0;
    chk_idle_zero("r1_late_ack");
    chk("r1_late_line", o_memory_line, 32'd0);
    tick();
    chk("r1_no_resp", 32'(o_memory_response),
        32'd0);

    // evict coincident with WB ack
    i_evict      = 1'b1;
    i_evict_addr = 32'h500;
    i_evict_data = 32'h77;
    tick();
    i_evict = 1'b0;
    tick();
    chk("c1_wb_addr", mem.addr, 32'h500);
    chk("c1_wb_data", mem.wdata, 32'h77);
    mem.ack      = 1'b1;
    i_evict      = 1'b1;
    i_evict_addr = 32'h600;
    i_evict_data = 32'h88;
    tick();
    mem.ack = 1'b0;
    i_evict = 1'b0;
    chk("c1_ovf", 32'(o_overflow), 32'd0);
    chk("c1_busy", 32'(o_busy), 32'd1);
    tick();
    chk("c1_wb2_addr", mem.addr, 32'h600);
    chk("c1_wb2_data", mem.wdata, 32'h88);
    mem.ack = 1'b1;
    tick();
    mem.ack = 1'b0;
    chk("c1_done", 32'(o_busy), 32'd0);
    chk("c1_ovf_end", 32'(o_overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
